// File: rtl/wport_pkg.sv
// Shared types for the register-file write-port arbiter.
// An entry is one buffered secondary result; live=0 means it was superseded.
package wport_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;

    typedef struct packed {
        logic                  live;
        logic [REG_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]     data;
    } wport_entry_t;

endpackage

// File: rtl/wport_fifo.sv
// Circular buffer of secondary results with per-entry kill-by-address
// and parallel address matching against the two decode source registers.
module wport_fifo
    import wport_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  wport_entry_t          push_entry,
    input  logic                  pop,
    input  logic                  kill_en,
    input  logic [REG_ADDR_W-1:0] kill_addr,
    input  logic [REG_ADDR_W-1:0] match_addr0,
    input  logic [REG_ADDR_W-1:0] match_addr1,
    output logic                  match0,
    output logic                  match1,
    output logic                  full,
    output logic                  empty,
    output wport_entry_t          head
);

    localparam int AW = $clog2(DEPTH);

    wport_entry_t     entry_q [DEPTH];
    wport_entry_t     entry_d [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [DEPTH-1:0] hit0, hit1;
    logic             do_push, do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head    = entry_q[rd_ptr_q[AW-1:0]];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Popped slots get live cleared, so only occupied slots can ever be live.
    always_comb begin
        entry_d  = entry_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (kill_en && entry_q[i].addr == kill_addr) begin
                entry_d[i].live = 1'b0;
            end
        end
        if (do_pop) begin
            entry_d[rd_ptr_q[AW-1:0]].live = 1'b0;
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
        if (do_push) begin
            entry_d[wr_ptr_q[AW-1:0]] = push_entry;
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= entry_d[i];
            end
        end
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
        assign hit0[gi] = entry_q[gi].live && (entry_q[gi].addr == match_addr0);
        assign hit1[gi] = entry_q[gi].live && (entry_q[gi].addr == match_addr1);
    end

    assign match0 = |hit0;
    assign match1 = |hit1;

endmodule

// File: rtl/rf_wport_arb.sv
// Register-file write-port arbiter: writeback always wins, buffered
// secondary results fill idle slots, with starvation-driven stall request.
module rf_wport_arb
    import wport_pkg::*;
#(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wb_we,
    input  logic [REG_ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0]     wb_data,
    input  logic                  md_valid,
    output logic                  md_ready,
    input  logic [REG_ADDR_W-1:0] md_addr,
    input  logic [DATA_W-1:0]     md_data,
    input  logic [REG_ADDR_W-1:0] rd_addr0,
    input  logic [REG_ADDR_W-1:0] rd_addr1,
    output logic                  pend0,
    output logic                  pend1,
    output logic                  stall_req,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_addr,
    output logic [DATA_W-1:0]     rf_data
);

    localparam int CW = $clog2(STARVE_MAX + 1);

    wport_entry_t head;
    wport_entry_t push_entry;
    logic         full, empty, match0, match1;
    logic         wb_eff, md_acc, push, pop, sec_grant;
    logic [CW-1:0] cnt_q, cnt_d;

    assign wb_eff    = wb_we && (wb_addr != '0);
    assign md_ready  = !full;
    assign md_acc    = md_valid && md_ready;
    assign push      = md_acc && (md_addr != '0);
    assign sec_grant = !wb_eff && !empty && head.live;
    assign pop       = !empty && (!head.live || sec_grant);

    // A result arriving alongside a younger primary write to the same register is born dead.
    always_comb begin
        push_entry      = '0;
        push_entry.live = !(wb_eff && (md_addr == wb_addr));
        push_entry.addr = md_addr;
        push_entry.data = md_data;
    end

    wport_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .kill_en    (wb_eff),
        .kill_addr  (wb_addr),
        .match_addr0(rd_addr0),
        .match_addr1(rd_addr1),
        .match0     (match0),
        .match1     (match1),
        .full       (full),
        .empty      (empty),
        .head       (head)
    );

    assign pend0 = match0 && (rd_addr0 != '0);
    assign pend1 = match1 && (rd_addr1 != '0);

    always_comb begin
        rf_we   = 1'b0;
        rf_addr = '0;
        rf_data = '0;
        if (wb_eff) begin
            rf_we   = 1'b1;
            rf_addr = wb_addr;
            rf_data = wb_data;
        end else if (sec_grant) begin
            rf_we   = 1'b1;
            rf_addr = head.addr;
            rf_data = head.data;
        end
    end

    // Saturating count of cycles a live head has been waiting.
    always_comb begin
        cnt_d = cnt_q;
        if (empty || !head.live || sec_grant) begin
            cnt_d = '0;
        end else if (cnt_q < CW'(STARVE_MAX)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign stall_req = (cnt_q >= CW'(STARVE_MAX));

endmodule

// File: tb/tb_rf_wport_arb.sv
// Directed bench for rf_wport_arb: drives vectors just after each rising
// edge and checks outputs 1 ns later against hand-computed values.
module tb_rf_wport_arb;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        md_valid;
    logic        md_ready;
    logic [4:0]  md_addr;
    logic [31:0] md_data;
    logic [4:0]  rd_addr0, rd_addr1;
    logic        pend0, pend1, stall_req, rf_we;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    rf_wport_arb #(.DEPTH(2), .STARVE_MAX(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .wb_we    (wb_we),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .md_valid (md_valid),
        .md_ready (md_ready),
        .md_addr  (md_addr),
        .md_data  (md_data),
        .rd_addr0 (rd_addr0),
        .rd_addr1 (rd_addr1),
        .pend0    (pend0),
        .pend1    (pend1),
        .stall_req(stall_req),
        .rf_we    (rf_we),
        .rf_addr  (rf_addr),
        .rf_data  (rf_data)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
            $display("ok   %s: %0h", tag, got);
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; wb_we = 1'b1; wb_addr = 5'd2; wb_data = 32'h0000_0222;
        md_valid = 1'b0; md_addr = '0; md_data = '0; rd_addr0 = '0; rd_addr1 = '0;
        #1;
        check("rst_md_ready", md_ready, 1);
        check("rst_pend0", pend0, 0);
        check("rst_stall", stall_req, 0);
        check("rst_rf_addr_mirror", rf_addr, 2);
        check("rst_rf_data_mirror", rf_data, 32'h0000_0222);
        cyc(); cyc();
        reset = 1'b0; wb_we = 1'b0;

        // single secondary result, written the cycle after acceptance
        md_valid = 1'b1; md_addr = 5'd5; md_data = 32'hA5A5_0001; rd_addr0 = 5'd5;
        #1;
        check("t1_accept_ready", md_ready, 1);
        check("t1_no_write_yet", rf_we, 0);
        check("t1_pend_not_yet", pend0, 0);
        cyc();
        md_valid = 1'b0;
        #1;
        check("t1_rf_we", rf_we, 1);
        check("t1_rf_addr", rf_addr, 5);
        check("t1_rf_data", rf_data, 32'hA5A5_0001);
        check("t1_pend_high", pend0, 1);
        cyc();
        check("t1_pend_low", pend0, 0);
        check("t1_idle", rf_we, 0);

        // fill while writeback hogs the port, watch starvation
        wb_we = 1'b1; wb_addr = 5'd9; wb_data = 32'h0000_0099;
        md_valid = 1'b1; md_addr = 5'd3; md_data = 32'h0000_0333;
        #1;
        check("t2_wb_data", rf_data, 32'h0000_0099);
        cyc();
        md_addr = 5'd4; md_data = 32'h0000_0444;
        #1;
        check("t2_ready_one", md_ready, 1);
        cyc();
        md_valid = 1'b0;
        check("t2_full", md_ready, 0);
        for (int k = 1; k <= 9; k++) begin
            check($sformatf("t2_stall_k%0d", k), stall_req, (k >= 8) ? 1 : 0);
            check($sformatf("t2_rf_addr_k%0d", k), rf_addr, 9);
            cyc();
        end
        wb_we = 1'b0;
        #1;
        check("t2_drain_addr", rf_addr, 3);
        check("t2_drain_data", rf_data, 32'h0000_0333);
        check("t2_stall_still", stall_req, 1);
        cyc();
        wb_we = 1'b1;
        check("t2_stall_fall", stall_req, 0);
        check("t2_ready_again", md_ready, 1);
        cyc();
        wb_we = 1'b0;
        #1;
        check("t2_drain4_addr", rf_addr, 4);
        check("t2_drain4_data", rf_data, 32'h0000_0444);
        cyc();
        check("t2_empty_idle", rf_we, 0);

        // buffered $7 superseded by a primary write
        wb_we = 1'b1; wb_addr = 5'd1; wb_data = 32'h0000_0001;
        md_valid = 1'b1; md_addr = 5'd7; md_data = 32'h0000_0011; rd_addr1 = 5'd7;
        cyc();
        md_valid = 1'b0; wb_addr = 5'd7; wb_data = 32'h0000_0022;
        #1;
        check("t3_pend_before", pend1, 1);
        check("t3_wb_data", rf_data, 32'h0000_0022);
        cyc();
        wb_we = 1'b0;
        #1;
        check("t3_pend_dropped", pend1, 0);
        check("t3_dead_no_write", rf_we, 0);
        cyc();
        check("t3_still_no_write", rf_we, 0);

        // same-cycle accept and primary write to $6
        wb_we = 1'b1; wb_addr = 5'd6; wb_data = 32'h0000_0044;
        md_valid = 1'b1; md_addr = 5'd6; md_data = 32'h0000_0033; rd_addr0 = 5'd6;
        #1;
        check("t4_rf_data", rf_data, 32'h0000_0044);
        cyc();
        wb_we = 1'b0; md_valid = 1'b0;
        #1;
        check("t4_dead_pend", pend0, 0);
        check("t4_dead_no_write", rf_we, 0);
        cyc();
        check("t4_no_write_after", rf_we, 0);

        // $0 secondary is swallowed; wb to $0 counts as idle
        wb_we = 1'b1; wb_addr = 5'd12; wb_data = 32'h0000_0012;
        md_valid = 1'b1; md_addr = 5'd0; md_data = 32'hDEAD_0000;
        cyc();
        md_addr = 5'd10; md_data = 32'h0000_0100;
        cyc();
        md_valid = 1'b0; rd_addr0 = 5'd0;
        check("t5_one_entry_ready", md_ready, 1);
        check("t5_pend_r0", pend0, 0);
        wb_addr = 5'd0; wb_data = 32'hDEAD_BEEF;
        #1;
        check("t5_wb0_drain_addr", rf_addr, 10);
        check("t5_wb0_drain_data", rf_data, 32'h0000_0100);
        cyc();
        check("t5_empty_after", rf_we, 0);

        // reset in the middle of a drain with two entries
        wb_addr = 5'd12;
        md_valid = 1'b1; md_addr = 5'd13; md_data = 32'h0000_0013;
        rd_addr0 = 5'd13; rd_addr1 = 5'd14;
        cyc();
        md_addr = 5'd14; md_data = 32'h0000_0014;
        cyc();
        md_valid = 1'b0; wb_we = 1'b0;
        #1;
        check("t6_full", md_ready, 0);
        check("t6_pend0", pend0, 1);
        check("t6_drain_addr", rf_addr, 13);
        reset = 1'b1;
        #1;
        check("t6_rst_ready", md_ready, 1);
        check("t6_rst_pend0", pend0, 0);
        check("t6_rst_pend1", pend1, 0);
        check("t6_rst_no_write", rf_we, 0);
        cyc();
        reset = 1'b0;
        #1;
        check("t6_post_no_write", rf_we, 0);
        cyc();
        check("t6_post2_no_write", rf_we, 0);
        check("t6_post_pend1", pend1, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rf_wport_arb.md
# rf_wport_arb

Arbiter for the single register-file write port.
- Shares the port between the pipeline writeback stage and a long-latency secondary result source (multiply/divide or CP0 completion).
- The writeback stage is the primary requester. It always wins and is never back-pressured.
- Secondary results are buffered in a small FIFO and drained into idle writeback slots.
- Pending-write status is exported so decode can stall; a starvation guard forces bubbles when needed.

## Interface
Parameters:
- DEPTH, 2 — secondary buffer entries (power of two, ≥2)
- STARVE_MAX, 8 — consecutive ungranted cycles before stall_req asserts

Ports:
- clk  in  1  single clock; all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- wb_we  in  1  primary write request (writeback-stage RFWr)
- wb_addr  in  5  primary destination register
- wb_data  in  32  primary write data
- md_valid  in  1  secondary result valid
- md_ready  out  1  secondary may enqueue (buffer not full)
- md_addr  in  5  secondary destination register
- md_data  in  32  secondary write data
- rd_addr0 / rd_addr1  in  5 each  decode-stage source registers
- pend0 / pend1  out  1 each  a live buffered entry targets rd_addrN (never for $0)
- stall_req  out  1  starvation: upstream must inject a writeback bubble
- rf_we  out  1  register-file write enable
- rf_addr  out  5  register-file write address
- rf_data  out  32  register-file write data

## Operation
Write filtering:
- A primary write is effective when wb_we=1 and wb_addr≠0.
- A secondary accept occurs on md_valid & md_ready.
- An accepted secondary with md_addr=0 is consumed but not enqueued.

Buffer entries:
- Each entry holds {live, addr, data}. Enqueue at tail on accept. md_ready = ~full. There is no pass-through when full.

Grant (combinational):
- If the primary write is effective, the rf port carries wb_*, unchanged.
- Otherwise, if the head entry is live, the rf port carries the head, and the head pops.
- Otherwise rf_we=0, rf_addr=0, rf_data=0.

Dead head:
- A head with live=0 pops in any cycle, regardless of wb_we, and produces no write.

Supersede (kill):
- Secondary results are older in program order than the current primary write.
- On an effective primary write, every buffered entry with addr==wb_addr gets live cleared that cycle.
- An entry being accepted in the same cycle with md_addr==wb_addr is enqueued dead.

Pending outputs:
- pendN = OR over live entries of (addr==rd_addrN), and rd_addrN≠0.
- Pending is computed on registered state only; a same-cycle accept is visible next cycle.

Starvation:
- The counter increments each cycle the head is live and not granted.
- It clears on grant, on an empty buffer, or on a dead head.
- stall_req = (count ≥ STARVE_MAX). It deasserts the cycle after the head is granted.

## Timing
- Primary path: zero latency, combinational wb_* → rf_*.
- Secondary: earliest write is the cycle after acceptance.
- Simultaneous enqueue and dequeue on a non-full buffer keeps the count unchanged.
- Pointers wrap modulo DEPTH.
- Reset (async, any time):
  - Buffer empty, counter 0.
  - Outputs: md_ready=1, pend0=pend1=0, stall_req=0; rf_* mirrors the primary-path filtering.
  - In-flight secondary data is discarded.
  - The first post-reset edge may accept.

## Structure
- Shared package wport_pkg:
  - REG_ADDR_W=5, DATA_W=32
  - packed struct wport_entry_t {live, addr, data}
- Sub-module wport_fifo: DEPTH-entry circular buffer.
  - Per-entry kill-by-address port.
  - Parallel address-match outputs for pending detection.
  - full/empty outputs and head exposure.
- Top level holds grant, filtering and the starvation counter.

## Test plan
- Reset, then md_valid with addr=5, data=0xA5A5_0001 while wb_we=0 → accepted; next cycle rf_we=1, rf_addr=5, rf_data=0xA5A5_0001; pend for 5 high for exactly that one cycle.
- Fill DEPTH=2 with $3 then $4 while wb_we=1 to $9 continuously → md_ready=0 after second accept; rf_* carries $9 every cycle; stall_req rises after 8 ungranted cycles; one wb_we=0 cycle → $3 written, stall_req falls next cycle.
- Buffer holds $7=0x11; primary writes $7=0x22 → $7 entry killed; never written afterward; pend for 7 drops next cycle.
- Same cycle: md accept $6=0x33 and primary write $6=0x44 → rf gets 0x44 only; buffered $6 is dead and pops silently.
- md_addr=0 accepted → no enqueue and no write; pending for rd_addr=0 always 0; wb_addr=0 with wb_we=1 is treated as idle, so the head drains.
- Assert reset mid-drain with 2 entries → immediately empty, md_ready=1, pend0=pend1=0, no stale write after release.
